// File: rtl/phy_clk_pkg.sv
// Shared types and constants for the PHY clock gating controller.
package phy_clk_pkg;

  // Per-channel gate FSM states; encoding is fixed so that debug views
  // and any downstream decode agree on the values.
  typedef enum logic [1:0] {
    OFF  = 2'b00,
    WAKE = 2'b01,
    ON   = 2'b10,
    IDLE = 2'b11
  } clk_gate_state_t;

  // Legal parameter ranges for the controller.
  localparam int NUM_CH_MIN   = 1;
  localparam int NUM_CH_MAX   = 16;
  localparam int WAKE_CYC_MIN = 1;
  localparam int WAKE_CYC_MAX = 15;

  // Wake counter is sized for the largest legal WAKE_CYC.
  localparam int WAKE_CNT_W = 4;

  // Value loaded into the wake counter on OFF -> WAKE. The counter is
  // checked for zero in WAKE, so WAKE_CYC-1 gives ch_ack WAKE_CYC edges
  // after the request was sampled.
  function automatic logic [WAKE_CNT_W-1:0] wake_load(input int wake_cyc);
    return WAKE_CNT_W'(wake_cyc - 1);
  endfunction

endpackage

// File: rtl/phy_clk_gate_cell.sv
// Glitch-free clock gate slice: wraps the technology ICG cell.
// The enable is captured by a latch that is transparent while clk is low,
// so enable changes launched from rising-edge flops can never truncate or
// glitch a high phase of gclk.
module phy_clk_gate_cell (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic gclk
);

`ifdef USE_TSMC_N4P_LIB
  (* dont_touch = "true" *)
  CKLNQD4BWP143M169H3P48CPDLVT u_icg (
    .CP (clk),
    .E  (en),
    .TE (te),
    .Q  (gclk)
  );
`elsif SYNTHESIS
  // A behavioural gate must never reach a netlist: it would be timed as
  // ordinary logic and lose the ICG's glitch guarantees.
  $error("phy_clk_gate_cell: define USE_TSMC_N4P_LIB to map the ICG cell");
`else
  logic en_lat;

  // Enable latch, transparent while clk is low (simulation model of the ICG).
  always_latch begin
    if (!clk) en_lat = en | te;
  end

  assign gclk = clk & en_lat;
`endif

endmodule

// File: rtl/phy_clk_gate_ctrl.sv
// Multi-channel PHY clock gating controller.
// Each channel opens its gate on a request, acknowledges once the gated
// clock has been running for WAKE_CYC edges, and closes again after
// cfg_idle_limit consecutive idle cycles. Force-on and scan only widen the
// ICG enable; they never touch the FSM, ch_ack or ch_gated.
module phy_clk_gate_ctrl
  import phy_clk_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic [IDLE_W-1:0] cfg_idle_limit,
  input  logic [NUM_CH-1:0] cfg_force_on,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ch_gated,
  output logic              all_gated
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("phy_clk_gate_ctrl: NUM_CH out of range");
  end
  if (WAKE_CYC < WAKE_CYC_MIN || WAKE_CYC > WAKE_CYC_MAX) begin : g_bad_wake_cyc
    $error("phy_clk_gate_ctrl: WAKE_CYC out of range");
  end
  if (IDLE_W < 1) begin : g_bad_idle_w
    $error("phy_clk_gate_ctrl: IDLE_W must be at least 1");
  end

  logic [NUM_CH-1:0] fsm_en;
  logic [NUM_CH-1:0] ack;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gate_state_t       state_q, state_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                  en_q, en_d;
    logic                  ack_q, ack_d;
    logic                  idle_cond;
    logic                  icg_en;

    // Channel is idle only when neither a request nor activity is present.
    assign idle_cond = ~ch_req[i] & ~ch_busy[i];

    // State, counters and registered outputs; async reset closes the gate
    // at once (the ICG latch follows while clk is low).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= OFF;
        wake_cnt_q <= '0;
        idle_cnt_q <= '0;
        en_q       <= 1'b0;
        ack_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        wake_cnt_q <= wake_cnt_d;
        idle_cnt_q <= idle_cnt_d;
        en_q       <= en_d;
        ack_q      <= ack_d;
      end
    end

    // Next-state logic: open on request, ack after wake, close after idling.
    always_comb begin
      state_d    = state_q;
      wake_cnt_d = wake_cnt_q;
      idle_cnt_d = idle_cnt_q;
      en_d       = en_q;
      ack_d      = ack_q;

      case (state_q)
        OFF: begin
          if (ch_req[i]) begin
            state_d    = WAKE;
            en_d       = 1'b1;
            wake_cnt_d = wake_load(WAKE_CYC);
          end
        end

        // Not abortable: the clock must be seen running before any
        // request drop is honoured.
        WAKE: begin
          if (wake_cnt_q == '0) begin
            state_d = ON;
            ack_d   = 1'b1;
          end else begin
            wake_cnt_d = wake_cnt_q - WAKE_CNT_W'(1);
          end
        end

        ON: begin
          if (idle_cond) begin
            idle_cnt_d = '0;
            if (cfg_idle_limit == '0) begin
              state_d = OFF;
              en_d    = 1'b0;
              ack_d   = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end

        // ch_ack stays high here; it only drops together with the gate.
        IDLE: begin
          if (!idle_cond) begin
            state_d    = ON;
            idle_cnt_d = '0;
          end else if (idle_cnt_q == cfg_idle_limit) begin
            state_d = OFF;
            en_d    = 1'b0;
            ack_d   = 1'b0;
          end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end

        default: begin
          state_d = OFF;
          en_d    = 1'b0;
          ack_d   = 1'b0;
        end
      endcase
    end

    // Force-on widens the functional enable; scan drives the test enable.
    assign icg_en = en_q | cfg_force_on[i];

    phy_clk_gate_cell u_gate (
      .clk  (clk),
      .en   (icg_en),
      .te   (scan_en),
      .gclk (clk_out[i])
    );

    assign fsm_en[i] = en_q;
    assign ack[i]    = ack_q;
  end

  assign ch_ack    = ack;
  assign ch_gated  = ~fsm_en;
  assign all_gated = &ch_gated;

endmodule

// File: tb/tb_phy_clk_gate_ctrl.sv
// Testbench for phy_clk_gate_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a cycle-count model.
module tb_phy_clk_gate_ctrl;
  localparam int NUM_CH   = 4;
  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              scan_en;
  logic [IDLE_W-1:0] cfg_idle_limit;
  logic [NUM_CH-1:0] cfg_force_on;
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_ack;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] ch_gated;
  logic              all_gated;

  int checks   = 0;
  int failures = 0;

  // Reference model: gate open flag, ack flag, remaining wake edges and
  // length of the current run of consecutive idle samples while acked.
  int m_open [NUM_CH];
  int m_ack  [NUM_CH];
  int m_wake [NUM_CH];
  int m_run  [NUM_CH];

  logic [NUM_CH-1:0] smp_clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] force_on;
    logic       scan;
    logic [3:0] ack;
    logic [3:0] gated;
    logic [3:0] clko;
  } vec_t;

  vec_t tbl [19];
  int   lims [3];

  phy_clk_gate_ctrl #(
    .NUM_CH   (NUM_CH),
    .IDLE_W   (IDLE_W),
    .WAKE_CYC (WAKE_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scan_en        (scan_en),
    .cfg_idle_limit (cfg_idle_limit),
    .cfg_force_on   (cfg_force_on),
    .ch_req         (ch_req),
    .ch_busy        (ch_busy),
    .ch_ack         (ch_ack),
    .clk_out        (clk_out),
    .ch_gated       (ch_gated),
    .all_gated      (all_gated)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_open[i] = 0;
      m_ack[i]  = 0;
      m_wake[i] = 0;
      m_run[i]  = 0;
    end
  endtask

  task automatic model_edge();
    int lim;
    int close_at;
    lim      = int'(cfg_idle_limit);
    close_at = (lim == 0) ? 1 : lim + 2;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_open[i] == 0) begin
        if (ch_req[i]) begin
          m_open[i] = 1;
          m_wake[i] = WAKE_CYC;
        end
      end else if (m_ack[i] == 0) begin
        m_wake[i]--;
        if (m_wake[i] == 0) begin
          m_ack[i] = 1;
          m_run[i] = 0;
        end
      end else if (!ch_req[i] && !ch_busy[i]) begin
        m_run[i]++;
        if (m_run[i] == close_at) begin
          m_open[i] = 0;
          m_ack[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  // One clock cycle: sample clk_out in the high phase, advance the model
  // on the edge, compare registered outputs at the falling edge.
  task automatic tick();
    logic [NUM_CH-1:0] exp_clk;
    logic [NUM_CH-1:0] exp_ack;
    logic [NUM_CH-1:0] exp_gated;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++)
      exp_clk[i] = (m_open[i] != 0) | cfg_force_on[i] | scan_en;
    smp_clk = clk_out;
    chk("model_clk_out", clk_out, exp_clk);
    if (!rst_n) model_reset();
    else        model_edge();
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      exp_ack[i]   = (m_ack[i] != 0);
      exp_gated[i] = (m_open[i] == 0);
    end
    chk("model_ch_ack", ch_ack, exp_ack);
    chk("model_ch_gated", ch_gated, exp_gated);
    chk("model_all_gated", all_gated, &exp_gated);
  endtask

  initial begin
    // req, busy, force, scan | ack, gated, clk_out(high phase of this edge)
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1110, 4'b0000};
    tbl[2]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1110, 4'b0001};
    tbl[3]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b1110, 4'b0001};
    tbl[4]  = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b1110, 4'b0001};
    tbl[5]  = '{4'b0000, 4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b1110, 4'b0001};
    for (int r = 6; r < 12; r++)
      tbl[r] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b1110, 4'b0001};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0001};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0000};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0100, 1'b1, 4'b0000, 4'b1111, 4'b1111};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0100, 1'b1, 4'b0000, 4'b1111, 4'b1111};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b1111, 4'b0100};
    tbl[17] = '{4'b0000, 4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b1111, 4'b0100};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0000};
    lims[0] = 0;
    lims[1] = 2;
    lims[2] = 6;

    // Reset with no requests, release in the middle of a high phase.
    rst_n          = 1'b0;
    scan_en        = 1'b0;
    cfg_idle_limit = 8'd5;
    cfg_force_on   = '0;
    ch_req         = '0;
    ch_busy        = '0;
    model_reset();
    tick();
    tick();
    chk("rst_ack", ch_ack, 4'b0000);
    chk("rst_gated", ch_gated, 4'b1111);
    chk("rst_all_gated", all_gated, 1'b1);
    chk("rst_clk_out", smp_clk, 4'b0000);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    tick();
    chk("rst_release_clk_out", smp_clk, 4'b0000);

    // Vector table: wake, busy hold, idle close with limit 5, scan/force.
    for (int r = 0; r < 19; r++) begin
      ch_req       = tbl[r].req;
      ch_busy      = tbl[r].busy;
      cfg_force_on = tbl[r].force_on;
      scan_en      = tbl[r].scan;
      tick();
      chk($sformatf("vec%0d_clk_out", r), smp_clk, tbl[r].clko);
      chk($sformatf("vec%0d_ack", r), ch_ack, tbl[r].ack);
      chk($sformatf("vec%0d_gated", r), ch_gated, tbl[r].gated);
    end

    // Busy pulse three edges into the idle run restarts the idle count.
    ch_req = 4'b0001;
    for (int w = 0; w < 10 && ch_ack[0] !== 1'b1; w++) tick();
    chk("busy_seq_wake_ack", ch_ack[0], 1'b1);
    ch_req = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      ch_busy = (k == 3) ? 4'b0001 : 4'b0000;
      tick();
      chk($sformatf("busy_seq_ack_k%0d", k), ch_ack[0], (k < 10) ? 1'b1 : 1'b0);
    end
    ch_busy = 4'b0000;

    // Idle limit 0: request dropped during WAKE gives a one-cycle ack.
    rst_n = 1'b0;
    model_reset();
    cfg_idle_limit = 8'd0;
    tick();
    rst_n  = 1'b1;
    ch_req = 4'b0010;
    tick();
    chk("l0_wake_ack_n0", ch_ack[1], 1'b0);
    ch_req = 4'b0000;
    tick();
    chk("l0_wake_ack_n1", ch_ack[1], 1'b0);
    tick();
    chk("l0_pulse_ack_n2", ch_ack[1], 1'b1);
    tick();
    chk("l0_pulse_ack_n3", ch_ack[1], 1'b0);
    chk("l0_pulse_gated_n3", ch_gated[1], 1'b1);

    // Idle limit 0 from a held request: closes on the first idle edge.
    ch_req = 4'b0100;
    for (int w = 0; w < 10 && ch_ack[2] !== 1'b1; w++) tick();
    chk("l0_hold_ack", ch_ack[2], 1'b1);
    ch_req = 4'b0000;
    tick();
    chk("l0_close_ack", ch_ack[2], 1'b0);
    chk("l0_close_gated", ch_gated[2], 1'b1);
    tick();
    chk("l0_close_clk_out", smp_clk[2], 1'b0);

    // Reset asserted mid-operation while clk is low stops everything at once.
    cfg_idle_limit = 8'd3;
    ch_req = 4'b1001;
    for (int w = 0; w < 10 && ch_ack !== 4'b1001; w++) tick();
    chk("midrst_ack_before", ch_ack, 4'b1001);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_clk_out", clk_out, 4'b0000);
    chk("midrst_ack", ch_ack, 4'b0000);
    chk("midrst_gated", ch_gated, 4'b1111);
    chk("midrst_all_gated", all_gated, 1'b1);
    tick();
    chk("midrst_next_clk_out", smp_clk, 4'b0000);
    ch_req = 4'b0000;
    rst_n  = 1'b1;

    // Randomized traffic, one block per idle limit.
    for (int b = 0; b < 3; b++) begin
      rst_n        = 1'b0;
      ch_req       = '0;
      ch_busy      = '0;
      cfg_force_on = '0;
      scan_en      = 1'b0;
      model_reset();
      cfg_idle_limit = IDLE_W'(lims[b]);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          ch_req[i]       = ($urandom_range(0, 3) == 0);
          ch_busy[i]      = ($urandom_range(0, 7) == 0);
          cfg_force_on[i] = ($urandom_range(0, 15) == 0);
        end
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
